seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with a dead-time blank at each slot start,
// leading-zero blanking, and a load handshake that holds a pending value until a frame boundary.
module seg_scan_ctrl #(
   parameter int DIV  = 100000,
   parameter int DEAD = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic [3:0]  dp,
   input  logic        lzb,
   input  logic        load,
   output logic        ready,
   input  logic        enable,
   output logic [7:0]  seg,
   output logic [3:0]  anode
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, PEND} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    dig_q, dig_d;
   logic [15:0]   disp_val_q, disp_val_d, pend_val_q, pend_val_d;
   logic [3:0]    disp_dp_q, disp_dp_d, pend_dp_q, pend_dp_d;
   logic          disp_lzb_q, disp_lzb_d, pend_lzb_q, pend_lzb_d;
   logic [3:0]    anode_q, anode_d;
   logic [7:0]    seg_q, seg_d;

   logic          run, tick, frame_end, accept, lit, upper_zero;
   logic [3:0]    nib;

   function automatic logic [6:0] hex_font(input logic [3:0] n);
      case (n)
         4'h0: hex_font = 7'h7E;
         4'h1: hex_font = 7'h30;
         4'h2: hex_font = 7'h6D;
         4'h3: hex_font = 7'h79;
         4'h4: hex_font = 7'h33;
         4'h5: hex_font = 7'h5B;
         4'h6: hex_font = 7'h5F;
         4'h7: hex_font = 7'h70;
         4'h8: hex_font = 7'h7F;
         4'h9: hex_font = 7'h7B;
         4'hA: hex_font = 7'h77;
         4'hB: hex_font = 7'h1F;
         4'hC: hex_font = 7'h4E;
         4'hD: hex_font = 7'h3D;
         4'hE: hex_font = 7'h4F;
         default: hex_font = 7'h47;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dig_d      = dig_q;
      disp_val_d = disp_val_q;
      disp_dp_d  = disp_dp_q;
      disp_lzb_d = disp_lzb_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_lzb_d = pend_lzb_q;

      run       = (state_q != IDLE) && enable;
      tick      = run && (cnt_q == CW'(DIV - 1));
      frame_end = tick && (dig_q == 2'd0);
      accept    = load && (state_q != PEND);

      if (run) begin
         cnt_d = tick ? '0 : cnt_q + CW'(1);
         if (tick) dig_d = dig_q - 2'd1;
      end

      case (state_q)
         IDLE: if (accept) begin
            disp_val_d = value;
            disp_dp_d  = dp;
            disp_lzb_d = lzb;
            state_d    = SCAN;
         end
         SCAN: if (accept) begin
            pend_val_d = value;
            pend_dp_d  = dp;
            pend_lzb_d = lzb;
            state_d    = PEND;
         end
         default: if (frame_end) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            disp_lzb_d = pend_lzb_q;
            state_d    = SCAN;
         end
      endcase

      // Outputs are derived from next-state values so the registered pins line up with the counters.
      case (dig_d)
         2'd3:    begin nib = disp_val_d[15:12]; upper_zero = (disp_val_d[15:12] == 4'h0); end
         2'd2:    begin nib = disp_val_d[11:8];  upper_zero = (disp_val_d[15:8]  == 8'h0); end
         2'd1:    begin nib = disp_val_d[7:4];   upper_zero = (disp_val_d[15:4]  == 12'h0); end
         default: begin nib = disp_val_d[3:0];   upper_zero = 1'b0; end
      endcase

      lit     = (state_d != IDLE) && enable && (cnt_d >= CW'(DEAD));
      anode_d = lit ? ~(4'b0001 << dig_d) : 4'hF;
      seg_d   = lit ? {~disp_dp_d[dig_d], (disp_lzb_d && upper_zero) ? 7'h7F : ~hex_font(nib)}
                    : 8'hFF;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dig_q      <= 2'd0;
         disp_val_q <= 16'h0;
         disp_dp_q  <= 4'h0;
         disp_lzb_q <= 1'b0;
         pend_val_q <= 16'h0;
         pend_dp_q  <= 4'h0;
         pend_lzb_q <= 1'b0;
         anode_q    <= 4'hF;
         seg_q      <= 8'hFF;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dig_q      <= dig_d;
         disp_val_q <= disp_val_d;
         disp_dp_q  <= disp_dp_d;
         disp_lzb_q <= disp_lzb_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_lzb_q <= pend_lzb_d;
         anode_q    <= anode_d;
         seg_q      <= seg_d;
      end
   end

   assign ready = (state_q != PEND);
   assign anode = anode_q;
   assign seg   = seg_q;

endmodule
